// File: rtl/text_term_ctrl.sv
// Text-terminal cursor controller: turns received bytes into text-RAM cell writes
// on a COLS x ROWS grid. Define TEXT_TERM_ROW_CLEAR_EN to blank each newly entered row.
module text_term_ctrl #(
  parameter int COLS = 32,
  parameter int ROWS = 4,
  localparam int COL_W = $clog2(COLS),
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             clear,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy,
  output logic             overflow
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_BLANK_ROW = 2'd1;
  localparam logic [1:0] ST_CLEAR_ALL = 2'd2;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [7:0]       SPACE    = 8'h20;

  logic [1:0]       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] seq_row_q, seq_row_d;
  logic [COL_W-1:0] seq_col_q, seq_col_d;
  logic             seq_done_q, seq_done_d;
  logic             hold_v_q, hold_v_d;
  logic [7:0]       hold_q, hold_d;
  logic             ovf_q, ovf_d;
  logic             wr_en_q, wr_en_d;
  logic [ROW_W-1:0] wr_row_q, wr_row_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             busy_q, busy_d;

  logic             byte_v;
  logic [7:0]       byte_b;
  logic             advance;
  logic [ROW_W-1:0] next_row;

  assign next_row = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    seq_row_d  = seq_row_q;
    seq_col_d  = seq_col_q;
    seq_done_d = seq_done_q;
    hold_v_d   = hold_v_q;
    hold_d     = hold_q;
    ovf_d      = ovf_q;
    wr_en_d    = 1'b0;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_data_d  = wr_data_q;
    busy_d     = 1'b0;
    byte_v     = 1'b0;
    byte_b     = '0;
    advance    = 1'b0;

    if (clear) begin
      // Cell (0,0) goes out on the entry edge; the counter resumes at (0,1).
      state_d    = ST_CLEAR_ALL;
      row_d      = '0;
      col_d      = '0;
      hold_v_d   = 1'b0;
      ovf_d      = 1'b0;
      wr_en_d    = 1'b1;
      wr_row_d   = '0;
      wr_col_d   = '0;
      wr_data_d  = SPACE;
      seq_row_d  = '0;
      seq_col_d  = COL_W'(1);
      seq_done_d = 1'b0;
      busy_d     = 1'b1;
    end else if (state_q == ST_IDLE) begin
      if (hold_v_q) begin
        byte_v   = 1'b1;
        byte_b   = hold_q;
        hold_v_d = rx_valid;
        if (rx_valid) hold_d = rx_data;
      end else if (rx_valid) begin
        byte_v = 1'b1;
        byte_b = rx_data;
      end
    end else begin
      if (rx_valid) begin
        if (!hold_v_q) begin
          hold_v_d = 1'b1;
          hold_d   = rx_data;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (seq_done_q) begin
        state_d = ST_IDLE;
      end else begin
        busy_d    = 1'b1;
        wr_en_d   = 1'b1;
        wr_data_d = SPACE;
        wr_col_d  = seq_col_q;
        if (state_q == ST_CLEAR_ALL) begin
          wr_row_d = seq_row_q;
          if (seq_col_q == COL_LAST) begin
            seq_col_d = '0;
            if (seq_row_q == ROW_LAST) seq_done_d = 1'b1;
            else                       seq_row_d  = seq_row_q + 1'b1;
          end else begin
            seq_col_d = seq_col_q + 1'b1;
          end
        end else begin
          wr_row_d = row_q;
          if (seq_col_q == COL_LAST) seq_done_d = 1'b1;
          else                       seq_col_d  = seq_col_q + 1'b1;
        end
      end
    end

    if (byte_v) begin
      if (byte_b == 8'h0D || byte_b == 8'h0A) begin
        col_d   = '0;
        row_d   = next_row;
        advance = 1'b1;
      end else if (byte_b == 8'h08) begin
        if (col_q != '0) begin
          col_d     = col_q - 1'b1;
          wr_en_d   = 1'b1;
          wr_row_d  = row_q;
          wr_col_d  = col_q - 1'b1;
          wr_data_d = SPACE;
        end
      end else if (byte_b >= 8'h20 && byte_b <= 8'h7E) begin
        wr_en_d   = 1'b1;
        wr_row_d  = row_q;
        wr_col_d  = col_q;
        wr_data_d = byte_b;
        if (col_q == COL_LAST) begin
          col_d   = '0;
          row_d   = next_row;
          advance = 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
`ifdef TEXT_TERM_ROW_CLEAR_EN
      // Blanking starts on the edge after the cursor move, so it targets the new row.
      if (advance) begin
        state_d    = ST_BLANK_ROW;
        seq_col_d  = '0;
        seq_done_d = 1'b0;
      end
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      seq_row_q  <= '0;
      seq_col_q  <= '0;
      seq_done_q <= 1'b0;
      hold_v_q   <= 1'b0;
      hold_q     <= '0;
      ovf_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      seq_row_q  <= seq_row_d;
      seq_col_q  <= seq_col_d;
      seq_done_q <= seq_done_d;
      hold_v_q   <= hold_v_d;
      hold_q     <= hold_d;
      ovf_q      <= ovf_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_row   = wr_row_q;
  assign wr_col   = wr_col_q;
  assign wr_data  = wr_data_q;
  assign cur_row  = row_q;
  assign cur_col  = col_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_text_term_ctrl.sv
// Self-checking bench for text_term_ctrl: directed scenarios plus random bytes,
// every cycle compared against a queue-based screen/cursor reference model.
module tb_text_term_ctrl;

  localparam int COLS  = 32;
  localparam int ROWS  = 4;
  localparam int CELLS = COLS * ROWS;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic             clk = 1'b0;
  logic             reset_n;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             clear;
  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [7:0]       wr_data;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             busy;
  logic             overflow;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cursor, hold slot, and a queue of pending blank-cell indices.
  int         m_row, m_col;
  bit         m_hold_v, m_ovf, m_seq;
  logic [7:0] m_hold_d;
  int         pend[$];
  bit         e_wr, e_busy;
  int         e_r, e_c;
  logic [7:0] e_d;

  text_term_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear(clear), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .cur_row(cur_row), .cur_col(cur_col),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input logic w, input logic [31:0] r, input logic [31:0] c,
                                       input logic [7:0] d, input logic [31:0] cr,
                                       input logic [31:0] cc, input logic b, input logic o);
    return {w, w ? 4'(r) : 4'd0, w ? 6'(c) : 6'd0, w ? d : 8'd0, 4'(cr), 6'(cc), b, o, 1'b0};
  endfunction

  function automatic logic [31:0] obs();
    return pack(wr_en, 32'(wr_row), 32'(wr_col), wr_data, 32'(cur_row), 32'(cur_col), busy, overflow);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (wr,row,col,data,cur_row,cur_col,busy,ovf) at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_hold_v = 0; m_hold_d = '0; m_ovf = 0; m_seq = 0;
    pend.delete();
  endtask

  task automatic pop_write();
    int k;
    k = pend.pop_front();
    e_wr = 1; e_r = k / COLS; e_c = k % COLS; e_d = 8'h20;
  endtask

  task automatic process(input logic [7:0] b);
    bit adv;
    adv = 0;
    if (b == 8'h0D || b == 8'h0A) begin
      m_col = 0; m_row = (m_row + 1) % ROWS; adv = 1;
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--; e_wr = 1; e_r = m_row; e_c = m_col; e_d = 8'h20;
      end
    end else if (b >= 8'h20 && b <= 8'h7E) begin
      e_wr = 1; e_r = m_row; e_c = m_col; e_d = b;
      if (m_col < COLS - 1) m_col++;
      else begin m_col = 0; m_row = (m_row + 1) % ROWS; adv = 1; end
    end
`ifdef TEXT_TERM_ROW_CLEAR_EN
    if (adv) begin
      pend.delete();
      for (int c = 0; c < COLS; c++) pend.push_back(m_row * COLS + c);
      m_seq = 1;
    end
`else
    if (adv) m_seq = 0;
`endif
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic c);
    logic [7:0] b;
    e_wr = 0; e_busy = 0;
    if (c) begin
      pend.delete();
      for (int k = 0; k < CELLS; k++) pend.push_back(k);
      m_row = 0; m_col = 0; m_hold_v = 0; m_ovf = 0; m_seq = 1;
      pop_write();
      e_busy = 1;
    end else if (m_seq) begin
      if (v) begin
        if (!m_hold_v) begin m_hold_v = 1; m_hold_d = d; end
        else m_ovf = 1;
      end
      if (pend.size() == 0) m_seq = 0;
      else begin pop_write(); e_busy = 1; end
    end else if (m_hold_v) begin
      b = m_hold_d;
      m_hold_v = v;
      if (v) m_hold_d = d;
      process(b);
    end else if (v) begin
      process(d);
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] d, input logic c);
    rx_valid = v; rx_data = d; clear = c;
    @(posedge clk);
    model_step(v, d, c);
    @(negedge clk);
    check("cycle", obs(), pack(e_wr, e_r, e_c, e_d, m_row, m_col, e_busy, m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = '0; clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset", {20'd0, wr_en, 2'(wr_row), 5'(wr_col), wr_data, 2'(cur_row), 5'(cur_col), busy, overflow}, 32'd0);
    reset_n = 1'b1;
    idle(2);

    tick(1'b1, 8'h41, 1'b0);
    check("first_A", obs(), pack(1, 0, 0, 8'h41, 0, 1, 0, 0));

    tick(1'b1, 8'h0D, 1'b0);
    idle(COLS + 3);
    tick(1'b1, 8'h0A, 1'b0);
    idle(COLS + 3);
    tick(1'b1, 8'h0A, 1'b0);
    idle(COLS + 3);
    for (int i = 0; i < COLS - 1; i++) tick(1'b1, 8'h41 + 8'(i % 26), 1'b0);
    check("at_3_31", obs(), pack(1, 3, 30, 8'h41 + 8'(30 % 26), 3, 31, 0, 0));
    tick(1'b1, 8'h5A, 1'b0);
    check("wrap_Z", obs(), pack(1, 3, 31, 8'h5A, 0, 0, 0, 0));
    idle(COLS + 3);

    tick(1'b1, 8'h0A, 1'b0);
    idle(COLS + 3);
    tick(1'b1, 8'h08, 1'b0);
    check("bs_col0", obs(), pack(0, 0, 0, 8'h00, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h61 + 8'(i), 1'b0);
    tick(1'b1, 8'h08, 1'b0);
    check("bs_1_5", obs(), pack(1, 1, 4, 8'h20, 1, 4, 0, 0));
    tick(1'b1, 8'h07, 1'b0);
    check("ignored", obs(), pack(0, 0, 0, 8'h00, 1, 4, 0, 0));

    tick(1'b1, 8'h41, 1'b1);
    check("clr_first", obs(), pack(1, 0, 0, 8'h20, 0, 0, 1, 0));
    idle(CELLS - 1);
    check("clr_last", obs(), pack(1, ROWS - 1, COLS - 1, 8'h20, 0, 0, 1, 0));
    idle(1);
    check("clr_done", obs(), pack(0, 0, 0, 8'h00, 0, 0, 0, 0));

    tick(1'b0, 8'h00, 1'b1);
    idle(3);
    tick(1'b1, 8'h78, 1'b0);
    idle(5);
    tick(1'b1, 8'h79, 1'b0);
    check("ovf_set", obs(), pack(1, 0, 10, 8'h20, 0, 0, 1, 1));
    idle(CELLS + 1 - 11);
    check("ovf_busy_low", obs(), pack(0, 0, 0, 8'h00, 0, 0, 0, 1));
    idle(1);
    check("held_x", obs(), pack(1, 0, 0, 8'h78, 0, 1, 0, 1));
    idle(2);
    tick(1'b0, 8'h00, 1'b1);
    check("ovf_cleared", obs(), pack(1, 0, 0, 8'h20, 0, 0, 1, 0));

    idle(20);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst", {27'd0, wr_en, busy, |cur_row, |cur_col, overflow}, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    for (int i = 0; i < 1500; i++) begin
      logic       v, c;
      logic [7:0] d;
      int         sel;
      v   = ($urandom_range(0, 99) < 60);
      c   = ($urandom_range(0, 399) == 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0:       d = 8'h0A;
        1:       d = 8'h0D;
        2:       d = 8'h08;
        3:       d = 8'($urandom_range(0, 255));
        default: d = 8'h20 + 8'($urandom_range(0, 94));
      endcase
      tick(v, d, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/text_term_ctrl.md
# text_term_ctrl

Parametrised text-terminal cursor controller. It converts a stream of received bytes (UART receiver output) into character-cell writes for the text RAM that the VGA text generator reads. It generalises the fixed 32x4 cursor logic to any COLS x ROWS grid. Over that logic it adds backspace, a full-screen clear sequence, a one-byte holding slot with a sticky overflow flag, and optional blanking of each newly entered row.

## Interface
- COLS, 32, characters per row (>= 2)
- ROWS, 4, rows on screen (>= 2)
- COL_W, $clog2(COLS), column index width (derived)
- ROW_W, $clog2(ROWS), row index width (derived)
- clk  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte, valid with rx_valid
- rx_valid  in  1  one-cycle strobe: rx_data is valid
- clear  in  1  one-cycle strobe: blank the screen and home the cursor
- wr_en  out  1  text RAM write strobe, one cycle per cell
- wr_row  out  ROW_W  write row address
- wr_col  out  COL_W  write column address
- wr_data  out  8  byte to write
- cur_row  out  ROW_W  current cursor row
- cur_col  out  COL_W  current cursor column
- busy  out  1  high while in BLANK_ROW or CLEAR_ALL
- overflow  out  1  sticky flag: a byte was dropped

## Operation
- All outputs are registered. Reset value of every output is 0.
- After reset the FSM is in IDLE and the hold slot is empty.
- FSM states: IDLE, BLANK_ROW, CLEAR_ALL.
- Byte source in IDLE:
  - If the hold slot is full, the held byte is processed and emptied.
  - A byte arriving on rx_valid in that same cycle is loaded into the hold slot.
  - Otherwise the byte on rx_valid is processed directly.
- Byte decode for byte b at cursor (r, c):
  - 0x0D or 0x0A (newline): c <= 0, r <= (r+1) mod ROWS; no write.
  - 0x08 (backspace):
    - c > 0: c <= c-1 and write 0x20 at (r, c-1).
    - c == 0: no-op, no write.
  - 0x20..0x7E (printable): write b at (r, c).
    - c < COLS-1: c <= c+1.
    - c == COLS-1: wrap; c <= 0, r <= (r+1) mod ROWS.
  - Any other value: ignored, cursor unchanged.
- Row ROWS-1 wraps to row 0. There is no scrolling.
- While busy=1 (byte arriving on rx_valid):
  - Hold slot empty: the byte is stored.
  - Hold slot full: the byte is dropped and overflow <= 1.
- CLEAR_ALL sequence:
  - Writes 0x20 to all ROWS*COLS cells in row-major order, (0,0) first.
  - Cursor is set to (0,0) on entry.
  - The hold slot is emptied and overflow is cleared on entry.
  - Returns to IDLE after the last cell.
- Priority:
  - clear beats rx_valid in the same cycle; that rx byte is discarded without setting overflow.
  - clear during BLANK_ROW or CLEAR_ALL aborts the sequence and restarts CLEAR_ALL from (0,0).
- reset_n low in the middle of a sequence returns everything to the reset values immediately. Cells already written stay written.

## Timing
- Direct byte with rx_valid at edge t (IDLE, hold empty):
  - Write: wr_en=1 with address/data during cycle t+1.
  - cur_row/cur_col show the updated cursor in cycle t+1.
- Held byte: processed in the first IDLE cycle after busy falls; its write appears one cycle later.
- wr_en is high for exactly one cycle per cell; it is never high in the cycle after a no-write byte.
- CLEAR_ALL with clear at edge t:
  - busy=1 from t+1 through t+ROWS*COLS.
  - Cell k (k = 0..ROWS*COLS-1) is written in cycle t+1+k.
  - busy=0 at t+ROWS*COLS+1.
- BLANK_ROW (only when compiled in; see Configuration):
  - Entered on every newline or wrap.
  - The printable write, if any, occurs first.
  - Then COLS consecutive cycles write 0x20 at (new row, 0..COLS-1), with busy=1 during those cycles.
- Throughput: at most one processed byte per cycle in IDLE.

## Configuration
- TEXT_TERM_ROW_CLEAR_EN defined:
  - Each newline or wrap enters BLANK_ROW.
  - The cursor row is updated before the blanking writes begin.
- Undefined:
  - Newline and wrap only move the cursor; old row contents remain.
  - BLANK_ROW is unreachable.
  - busy is asserted only by CLEAR_ALL.

## Test plan
- COLS=32, ROWS=4:
  - Stimulus: reset, then rx 'A' (0x41).
  - Response: one write (0,0,0x41) one cycle after the strobe; cursor (0,1).
- Wrap at last column and bottom row:
  - Stimulus: with the cursor at (3,31), rx 'Z'.
  - Response: write (3,31,0x5A), then cursor (0,0).
  - With the macro: 32 writes of 0x20 to row 0, busy high for 32 cycles.
- Backspace:
  - Stimulus: rx 0x08 at cursor (1,5).
  - Response: write (1,4,0x20), cursor (1,4).
  - At (1,0): no write, cursor unchanged.
- Full clear:
  - Stimulus: pulse clear.
  - Response: 128 consecutive writes of 0x20 from (0,0) to (3,31); busy for 128 cycles; cursor (0,0); overflow 0.
- Busy overflow:
  - Stimulus: during CLEAR_ALL, rx 'x' then 'y'.
  - Response: 'x' is held and written at (0,0) right after busy falls; 'y' is dropped; overflow=1 until the next clear.
- Async reset:
  - Stimulus: assert reset_n low mid-CLEAR_ALL.
  - Response: wr_en, busy, cursor and overflow are 0 without waiting for a clock edge.
